lcd_frame_scheduler: RTL and testbench
======================================

Name: lcd_frame_scheduler

Overview:
- Sits between the content producers and the LCD display/frame-RAM pair.
- Arbitrates write access to the 1024x8 LCD frame RAM write port among NUM_REQ requesters using round-robin.
- Tracks whether the frame has changed since the last refresh.
- Requests a full screen refresh from the display controller, rate-limited to at most one refresh per MIN_REFRESH_CYCLES.

Parameters:
- NUM_REQ, 3, number of write requesters.
- ADDR_W, 10, frame RAM address width (1024 bytes: 8 pages x 128 columns).
- DATA_W, 8, frame RAM data width.
- MIN_REFRESH_CYCLES, 120000, minimum sys_clk cycles from one refresh_done to the next refresh_req (10 ms at 12 MHz).
- CNT_W, 17, interval counter width; must satisfy 2^CNT_W > MIN_REFRESH_CYCLES.

Ports:
- sys_clk  in  1  system clock, 12 MHz.
- sys_rst_n  in  1  reset; synchronous, active-low.
- req  in  NUM_REQ  per-requester write request; held with addr/data until granted.
- req_addr  in  NUM_REQ*ADDR_W  packed write addresses; requester i uses slice i.
- req_data  in  NUM_REQ*DATA_W  packed write data.
- gnt  out  NUM_REQ  one-cycle grant pulse; the write is accepted in that cycle.
- addr_write  out  ADDR_W  frame RAM write address.
- data_write  out  DATA_W  frame RAM write data.
- write_en  out  1  frame RAM write enable, active-high.
- refresh_req  out  1  level request to the display controller to start a refresh.
- refresh_ack  in  1  one-cycle pulse: display has started a refresh.
- refresh_done  in  1  one-cycle pulse: display has finished and returned to idle.
- dirty  out  1  frame changed since the last acknowledged refresh.

Behaviour:
- Reset (sys_rst_n=0 at a clock edge) forces:
  - gnt=0, write_en=0, addr_write=0, data_write=0
  - refresh_req=0, dirty=0
  - FSM=IDLE, rr_ptr=0, interval counter=MIN_REFRESH_CYCLES (eligible immediately)
- Reset mid-write or mid-refresh abandons the operation. No pulse is replayed after reset.
- Arbiter:
  - Eligible set = req & ~gnt. The requester granted last cycle is masked for one cycle so a held request is not double-granted.
  - Search order starts at rr_ptr. The first eligible index k wins.
  - At the next edge the block registers gnt[k]=1, write_en=1, addr_write/data_write = slice k, and rr_ptr = k+1 mod NUM_REQ.
  - Latency is 1 cycle from req sampled to gnt/write_en.
  - One write per cycle maximum; gnt is one-hot or zero.
  - With no eligible request, write_en=0 and addr/data hold their last values.
  - A single requester therefore sustains 1 word per 2 cycles. Two or more active requesters give 1 word per cycle aggregate.
  - The requester drops req, or presents its next word, in the cycle it sees gnt high.
- Dirty flag:
  - Set in any cycle write_en=1.
  - Cleared on refresh_ack.
  - If write_en and refresh_ack coincide, set wins: dirty stays 1.
- Interval counter:
  - Cleared to 0 on refresh_done.
  - Otherwise increments, saturating at MIN_REFRESH_CYCLES.
  - interval_ok = (counter == MIN_REFRESH_CYCLES).
- Scheduler FSM:
  - IDLE -> REQ when dirty && interval_ok. refresh_req is registered and asserts on entry.
  - REQ holds refresh_req=1 until refresh_ack. It then goes to BUSY and drops refresh_req in the same edge.
  - BUSY waits for refresh_done, then goes to IDLE.
  - refresh_ack and refresh_done in the same cycle while in REQ: go directly to IDLE and clear the counter.
  - refresh_done outside BUSY/REQ is ignored for FSM state but still clears the counter.
  - refresh_ack outside REQ is ignored.
- Writes during BUSY proceed normally (tearing permitted) and re-set dirty, which schedules a follow-up refresh.

Optional Feature:
- Macro: LCD_FRAME_SCHED_TEAR_FREE_EN.
- Defined:
  - Eligible set is forced empty while FSM is BUSY, and in the REQ cycle where refresh_ack is high.
  - No frame RAM writes occur during a refresh. Requests stall and are served round-robin after refresh_done.
  - dirty therefore cannot be set during BUSY.
- Undefined: behaviour as above, with writes allowed at all times.

Decomposition:
- Shared package lcd_pkg holds:
  - LCD_ADDR_W=10, LCD_DATA_W=8, LCD_PAGES=8, LCD_COLS=128
  - the scheduler state enum (SCHED_IDLE, SCHED_REQ, SCHED_BUSY)
- One sub-module, lcd_rr_arbiter: parameterised round-robin picker. Inputs are eligible vector and rr_ptr; outputs are one-hot grant and valid. Combinational.
- Registers stay in lcd_frame_scheduler.

Test Plan:
- Bench uses MIN_REFRESH_CYCLES=16.
- Single writer: req[0] with addr=0x005, data=0xA5 -> next cycle gnt=001, write_en=1, addr_write=0x005, data_write=0xA5; no grant the following cycle; dirty=1.
- All three req held continuously -> gnt sequence 001,010,100,001,... with write_en=1 every cycle.
- After reset with no writes -> refresh_req stays 0. One write -> refresh_req=1 two cycles later. refresh_ack -> refresh_req=0, dirty=0.
- refresh_done, then write at +1 cycle -> refresh_req not asserted until 16 cycles after refresh_done.
- write_en coincident with refresh_ack -> dirty remains 1 and a second refresh_req follows interval expiry.
- With LCD_FRAME_SCHED_TEAR_FREE_EN, req[1] during BUSY -> gnt stays 0 until the cycle after refresh_done, then gnt=010. Sync reset asserted in BUSY -> all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: frame RAM geometry and the refresh scheduler state encoding.
// Frame RAM is 1024 bytes, organised as 8 pages x 128 columns.
package lcd_pkg;

  localparam int unsigned LCD_ADDR_W = 10;
  localparam int unsigned LCD_DATA_W = 8;
  localparam int unsigned LCD_PAGES  = 8;
  localparam int unsigned LCD_COLS   = 128;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_REQ,
    SCHED_BUSY
  } sched_state_e;

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   eligible  in   NUM_REQ  requesters allowed to win this cycle
//   rr_ptr    in   PTR_W    index where the search starts
//   grant     out  NUM_REQ  one-hot winner, zero when nothing is eligible
//   valid     out  1        a winner exists
module lcd_rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  logic [PTR_W-1:0] idx;

  // Walk indices rr_ptr, rr_ptr+1, ... (mod NUM_REQ); first eligible one wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!valid && eligible[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// LCD frame scheduler: round-robin arbitration of the frame RAM write port, frame dirty
// tracking and rate-limited full-screen refresh requests to the display controller.
// Optional build macro LCD_FRAME_SCHED_TEAR_FREE_EN: blocks frame RAM writes while a refresh
// is in progress (BUSY, and the REQ cycle in which refresh_ack arrives).
// Ports:
//   sys_clk, sys_rst_n            clock, synchronous active-low reset
//   req, req_addr, req_data       per-requester write request with packed address/data slices
//   gnt                           one-cycle grant pulse, write accepted in that cycle
//   addr_write, data_write        frame RAM write address/data
//   write_en                      frame RAM write enable
//   refresh_req                   level request to start a refresh
//   refresh_ack, refresh_done     display pulses: refresh started / finished
//   dirty                         frame changed since the last acknowledged refresh
module lcd_frame_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_REQ            = 3,
  parameter int unsigned ADDR_W             = LCD_ADDR_W,
  parameter int unsigned DATA_W             = LCD_DATA_W,
  parameter int unsigned MIN_REFRESH_CYCLES = 120000,
  parameter int unsigned CNT_W              = 17
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         addr_write,
  output logic [DATA_W-1:0]         data_write,
  output logic                      write_en,
  output logic                      refresh_req,
  input  logic                      refresh_ack,
  input  logic                      refresh_done,
  output logic                      dirty
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_REFRESH_CYCLES);

  sched_state_e        state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_REQ-1:0]  gnt_q, eligible, pick;
  logic                pick_valid;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                write_en_q, dirty_q;
  logic                interval_ok, write_block;

`ifdef LCD_FRAME_SCHED_TEAR_FREE_EN
  assign write_block = (state_q == SCHED_BUSY) || ((state_q == SCHED_REQ) && refresh_ack);
`else
  assign write_block = 1'b0;
`endif

  // Last cycle's winner is masked so a request held through its grant is not served twice.
  assign eligible    = req & ~gnt_q & {NUM_REQ{~write_block}};
  assign interval_ok = (cnt_q == CNT_MAX);

  lcd_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arbiter (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .grant    (pick),
    .valid    (pick_valid)
  );

  // Winner's slice goes to the write port; with no winner the port holds its last value.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) begin
        addr_d   = req_addr[k*ADDR_W +: ADDR_W];
        data_d   = req_data[k*DATA_W +: DATA_W];
        rr_ptr_d = (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCHED_IDLE: if (dirty_q && interval_ok) state_d = SCHED_REQ;
      SCHED_REQ: begin
        // ack and done together: the refresh already finished, skip BUSY.
        if (refresh_ack && refresh_done) state_d = SCHED_IDLE;
        else if (refresh_ack)            state_d = SCHED_BUSY;
      end
      SCHED_BUSY: if (refresh_done) state_d = SCHED_IDLE;
      default:    state_d = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= SCHED_IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= CNT_MAX;
      gnt_q      <= '0;
      write_en_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      dirty_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= pick;
      write_en_q <= pick_valid;
      addr_q     <= addr_d;
      data_q     <= data_d;
      // A write in the ack cycle must not be lost, so set beats clear.
      if (write_en_q)       dirty_q <= 1'b1;
      else if (refresh_ack) dirty_q <= 1'b0;
      if (refresh_done)     cnt_q <= '0;
      else if (!interval_ok) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign gnt         = gnt_q;
  assign write_en    = write_en_q;
  assign addr_write  = addr_q;
  assign data_write  = data_q;
  assign dirty       = dirty_q;
  assign refresh_req = (state_q == SCHED_REQ);

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Scoreboard bench for lcd_frame_scheduler with MIN_REFRESH_CYCLES=16.
// Stimulus pushes expected writes and timed signal probes; the monitor compares at negedge.
module tb_lcd_frame_scheduler;

  localparam int unsigned N = 3, AW = 10, DW = 8;
  localparam int SIG_DIRTY = 0, SIG_RREQ = 1, SIG_WEN = 2, SIG_GNT = 3, SIG_ADDR = 4,
                 SIG_DATA = 5;

  typedef struct {
    int         at;
    logic [2:0] gnt;
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    int          at;
    int          sig;
    logic [31:0] val;
  } probe_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  gnt;
  logic [AW-1:0] addr_write;
  logic [DW-1:0] data_write;
  logic          write_en, refresh_req, refresh_ack, refresh_done, dirty;

  wr_t    exp_wr[$];
  probe_t probes[$];
  int     cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  bit     stim_done = 1'b0;

  lcd_frame_scheduler #(
    .NUM_REQ            (N),
    .ADDR_W             (AW),
    .DATA_W             (DW),
    .MIN_REFRESH_CYCLES (16),
    .CNT_W              (5)
  ) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .req          (req),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .gnt          (gnt),
    .addr_write   (addr_write),
    .data_write   (data_write),
    .write_en     (write_en),
    .refresh_req  (refresh_req),
    .refresh_ack  (refresh_ack),
    .refresh_done (refresh_done),
    .dirty        (dirty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int k, input int sig, input logic [31:0] val);
    probe_t p;
    p.at = cyc + k; p.sig = sig; p.val = val;
    probes.push_back(p);
  endtask

  task automatic probe_reset(input int k);
    for (int s = 0; s <= SIG_DATA; s++) probe(k, s, 32'd0);
  endtask

  task automatic exp_write(input int k, input logic [2:0] g, input logic [9:0] a,
                           input logic [7:0] d);
    wr_t w;
    w.at = cyc + k; w.gnt = g; w.addr = a; w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic set_slice(input int i, input logic [9:0] a, input logic [7:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  function automatic logic [31:0] sig_val(input int sig);
    case (sig)
      SIG_DIRTY: return 32'(dirty);
      SIG_RREQ:  return 32'(refresh_req);
      SIG_WEN:   return 32'(write_en);
      SIG_GNT:   return 32'(gnt);
      SIG_ADDR:  return 32'(addr_write);
      SIG_DATA:  return 32'(data_write);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      SIG_DIRTY: return "dirty";
      SIG_RREQ:  return "refresh_req";
      SIG_WEN:   return "write_en";
      SIG_GNT:   return "gnt";
      SIG_ADDR:  return "addr_write";
      SIG_DATA:  return "data_write";
      default:   return "unknown";
    endcase
  endfunction

  // Monitor / scoreboard
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (write_en === 1'b1) begin
        vectors++;
        if (exp_wr.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write cyc=%0d: got gnt=%b addr=%h data=%h, required no write",
                   cyc, gnt, addr_write, data_write);
        end else begin
          w = exp_wr.pop_front();
          if (w.at != cyc || gnt !== w.gnt || addr_write !== w.addr || data_write !== w.data) begin
            miscompares++;
            $display("FAIL write: got cyc=%0d gnt=%b addr=%h data=%h, required cyc=%0d gnt=%b addr=%h data=%h",
                     cyc, gnt, addr_write, data_write, w.at, w.gnt, w.addr, w.data);
          end
        end
      end else if (exp_wr.size() != 0 && exp_wr[0].at <= cyc) begin
        vectors++;
        miscompares++;
        w = exp_wr.pop_front();
        $display("FAIL missing_write cyc=%0d: got write_en=%b gnt=%b, required write gnt=%b addr=%h data=%h",
                 cyc, write_en, gnt, w.gnt, w.addr, w.data);
      end
      for (int i = int'(probes.size()) - 1; i >= 0; i--) begin
        if (probes[i].at <= cyc) begin
          vectors++;
          if (probes[i].at != cyc || sig_val(probes[i].sig) !== probes[i].val) begin
            miscompares++;
            $display("FAIL probe %s cyc=%0d: got %h, required %h at cyc=%0d",
                     sig_name(probes[i].sig), cyc, sig_val(probes[i].sig), probes[i].val,
                     probes[i].at);
          end
          probes.delete(i);
        end
      end
      if (stim_done) begin
        vectors++;
        if (exp_wr.size() != 0) begin
          miscompares++;
          $display("FAIL pending_writes: got %0d outstanding, required 0", exp_wr.size());
        end
        vectors++;
        if (probes.size() != 0) begin
          miscompares++;
          $display("FAIL pending_probes: got %0d outstanding, required 0", probes.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, required finish within time limit");
    $fatal(1);
  end

  // Stimulus
  initial begin
    rst_n = 1'b0; req = '0; req_addr = '0; req_data = '0;
    refresh_ack = 1'b0; refresh_done = 1'b0;
    tick(); tick();
    probe_reset(0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    probe(0, SIG_RREQ, 0); probe(0, SIG_DIRTY, 0);

    // Single write; interval already satisfied so refresh_req follows two cycles later.
    set_slice(0, 10'h005, 8'hA5); req = 3'b001;
    exp_write(1, 3'b001, 10'h005, 8'hA5);
    probe(1, SIG_DIRTY, 0); probe(2, SIG_DIRTY, 1); probe(2, SIG_RREQ, 0); probe(3, SIG_RREQ, 1);
    tick(); req = '0;
    tick(); tick(); tick();
    probe(0, SIG_RREQ, 1);
    refresh_ack = 1'b1;
    probe(1, SIG_RREQ, 0); probe(1, SIG_DIRTY, 0);
    tick(); refresh_ack = 1'b0;
    tick(); tick();
    probe(0, SIG_RREQ, 0);

    // refresh_done then write one cycle later: refresh_req held off by the interval.
    refresh_done = 1'b1;
    tick(); refresh_done = 1'b0;
    set_slice(1, 10'h3FF, 8'h5A); req = 3'b010;
    exp_write(1, 3'b010, 10'h3FF, 8'h5A);
    probe(2, SIG_DIRTY, 1); probe(16, SIG_RREQ, 0); probe(17, SIG_RREQ, 1);
    tick(); req = '0;
    repeat (16) tick();

    // Write coincident with refresh_ack: dirty stays set, follow-up refresh after interval.
    set_slice(2, 10'h123, 8'h3C); req = 3'b100;
    exp_write(1, 3'b100, 10'h123, 8'h3C);
    tick(); req = '0; refresh_ack = 1'b1;
    probe(1, SIG_DIRTY, 1); probe(1, SIG_RREQ, 0);
    tick(); refresh_ack = 1'b0;
    tick();
    refresh_done = 1'b1;
    probe(17, SIG_RREQ, 0); probe(18, SIG_RREQ, 1);
    tick(); refresh_done = 1'b0;
    repeat (17) tick();

    // ack and done together in REQ: straight back to IDLE, counter restarted.
    refresh_ack = 1'b1; refresh_done = 1'b1;
    probe(1, SIG_RREQ, 0); probe(1, SIG_DIRTY, 0);
    tick(); refresh_ack = 1'b0; refresh_done = 1'b0;
    set_slice(0, 10'h010, 8'h81); req = 3'b001;
    exp_write(1, 3'b001, 10'h010, 8'h81);
    probe(16, SIG_RREQ, 0); probe(17, SIG_RREQ, 1);
    tick(); req = '0;
    repeat (16) tick();
    refresh_ack = 1'b1;
    tick(); refresh_ack = 1'b0;

    // Request during BUSY.
    set_slice(1, 10'h2AA, 8'h77); req = 3'b010;
`ifdef LCD_FRAME_SCHED_TEAR_FREE_EN
    exp_write(4, 3'b010, 10'h2AA, 8'h77);
    probe(1, SIG_DIRTY, 0); probe(2, SIG_DIRTY, 0);
    tick(); tick(); refresh_done = 1'b1;
    tick(); refresh_done = 1'b0;
    tick(); req = '0;
`else
    exp_write(1, 3'b010, 10'h2AA, 8'h77);
    probe(2, SIG_DIRTY, 1);
    tick(); req = '0;
    tick(); refresh_done = 1'b1;
    tick(); refresh_done = 1'b0;
    tick();
`endif
    repeat (16) tick();
    probe(0, SIG_RREQ, 1);
    refresh_ack = 1'b1;
    tick(); refresh_ack = 1'b0;

    // Reset asserted while BUSY with a write in flight.
    set_slice(0, 10'h0F0, 8'hC3); req = 3'b011;
`ifndef LCD_FRAME_SCHED_TEAR_FREE_EN
    exp_write(1, 3'b001, 10'h0F0, 8'hC3);
`endif
    tick(); rst_n = 1'b0; req = '0;
    probe_reset(1);
    tick(); rst_n = 1'b1;

    // All three requesters held: 001,010,100,... every cycle, pointer reset to 0.
    set_slice(0, 10'h001, 8'h11); set_slice(1, 10'h002, 8'h22); set_slice(2, 10'h003, 8'h33);
    req = 3'b111;
    probe(0, SIG_RREQ, 0);
    for (int i = 0; i < 6; i++) begin
      exp_write(i + 1, 3'(1 << (i % 3)), 10'(i % 3 + 1), 8'(17 * (i % 3 + 1)));
    end
    repeat (6) tick();
    req = '0;
    tick();

    // Single held requester: one word per two cycles.
    req = 3'b010;
    exp_write(1, 3'b010, 10'h002, 8'h22);
    exp_write(3, 3'b010, 10'h002, 8'h22);
    repeat (4) tick();
    req = '0;
    repeat (4) tick();
    stim_done = 1'b1;
  end

endmodule
